nios2vga_pio_in_capture: RTL

- Parametrised Avalon-MM input PIO slave for the Nios II VGA system; successor to the fixed 8-bit input port.
- Adds a multi-stage input synchroniser, per-bit edge capture, an interrupt mask and a level interrupt to the CPU.
- Sits between asynchronous board inputs (switches, keys, control strobes) and the Nios II data master.

---
 rtl/nios2vga_pio_pkg.sv | 13 +
 rtl/nios2vga_pio_debounce.sv | 43 ++++
 rtl/nios2vga_pio_in_capture.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nios2vga_pio_pkg.sv
// Shared constants for the Nios II VGA input PIO: register map and edge-type encodings.
package nios2vga_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios2vga_pio_debounce.sv
// One-bit debounce filter: the output follows the input only after it has
// differed from the output for DEBOUNCE_CYCLES consecutive cycles.
module nios2vga_pio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Any cycle where input and output agree restarts the stability count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (din != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = din;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/nios2vga_pio_in_capture.sv
// Avalon-MM input PIO with synchroniser, edge capture, IRQ mask and level irq.
// Optional per-bit debounce filter enabled by defining NIOS2VGA_PIO_IN_DEBOUNCE_EN.
module nios2vga_pio_in_capture
    import nios2vga_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int unsigned GUARD_W = $clog2(SYNC_STAGES + 2);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0] data_sync, data_clean;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] edge_det, cap_clr, rise, fall;
    logic [GUARD_W-1:0]    guard_q, guard_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  wr_en;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign data_sync = sync_q[SYNC_STAGES-1];

`ifdef NIOS2VGA_PIO_IN_DEBOUNCE_EN
    for (genvar b = 0; b < int'(DATA_WIDTH); b++) begin : g_db
        nios2vga_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (data_sync[b]),
            .dout   (data_clean[b])
        );
    end
`else
    assign data_clean = data_sync;
`endif

    // Startup guard masks the reset-to-live transition of the synchroniser.
    always_comb begin
        guard_d  = (guard_q == GUARD_LAST) ? guard_q : guard_q + GUARD_W'(1);
        prev_d   = data_clean;
        rise     = data_clean & ~prev_q;
        fall     = ~data_clean & prev_q;
        edge_det = '0;
        if (guard_q == GUARD_LAST) begin
            if (EDGE_TYPE == EDGE_RISE) begin
                edge_det = rise;
            end else if (EDGE_TYPE == EDGE_FALL) begin
                edge_det = fall;
            end else begin
                edge_det = rise | fall;
            end
        end
    end

    // Register writes; a newly detected edge overrides a same-cycle clear.
    always_comb begin
        wr_en   = chipselect & ~write_n;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en && (address == ADDR_IRQ_MASK)) begin
            mask_d = writedata[DATA_WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE_CAP)) begin
            cap_clr = writedata[DATA_WIDTH-1:0];
        end
        cap_d = (cap_q & ~cap_clr) | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = 32'(data_clean);
            ADDR_RSVD:     readdata_d = '0;
            ADDR_IRQ_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(cap_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            guard_q    <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            guard_q    <= guard_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule
